// File: rtl/block_cipher_stream.sv
// Toy stream block cipher: key/chain XOR plus adjacent-bit swap.
// ECB or CBC, valid/ready block streams in and out.
module block_cipher_stream #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_dec,
  input  logic             cbc_en,
  input  logic [W-1:0]     key,
  input  logic [W-1:0]     iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t     state;
  logic [W-1:0] key_q;
  logic [W-1:0] chain_q;
  logic         mode_q;
  logic         cbc_q;

  logic         acc_in;
  logic         acc_out;
  logic [W-1:0] chain_use;
  logic [W-1:0] res;
  logic [W-1:0] chain_nxt;

  function automatic logic [W-1:0] swap(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 2; i++) begin
      r[2*i]   = x[2*i+1];
      r[2*i+1] = x[2*i];
    end
    return r;
  endfunction

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign acc_in   = in_valid && in_ready;
  assign acc_out  = out_valid && out_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    chain_use = cbc_q ? chain_q : '0;
    res       = '0;
    chain_nxt = '0;
    unique case (1'b1)
      mode_q: begin
        res       = swap(in_data) ^ key_q ^ chain_use;
        chain_nxt = in_data;
      end
      default: begin
        res       = swap(in_data ^ key_q ^ chain_use);
        chain_nxt = res;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_q     <= '0;
      chain_q   <= '0;
      mode_q    <= 1'b0;
      cbc_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            key_q   <= key;
            chain_q <= iv;
            mode_q  <= mode_dec;
            cbc_q   <= cbc_en;
            blk_cnt <= '0;
          end
        end
        RUN: begin
          if (acc_in && in_last) state <= DRAIN;
        end
        DRAIN: begin
          if (acc_out && out_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // acc_in only happens in RUN, so it never races the start load above
      if (acc_in) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_last  <= in_last;
        blk_cnt   <= blk_cnt + CNT_W'(1);
        if (cbc_q) chain_q <= chain_nxt;
      end else if (acc_out) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_block_cipher_stream.sv
// Directed bench for block_cipher_stream (W=8).
// Vector table plus hand sequences for stalls, restarts and reset.
module tb_block_cipher_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode_dec = 1'b0;
  logic        cbc_en = 1'b0;
  logic [7:0]  key = '0;
  logic [7:0]  iv = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic [15:0] blk_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0] pt [256];
  logic [7:0] ct [256];
  logic [7:0] sbuf [256];
  logic [7:0] obuf [256];

  typedef struct {
    bit         md;
    bit         cbc;
    logic [7:0] k;
    logic [7:0] v;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [9];

  block_cipher_stream #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mode_dec(mode_dec), .cbc_en(cbc_en),
    .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_start(input bit md, input bit cbc,
                          input logic [7:0] k, input logic [7:0] v);
    start = 1'b1; mode_dec = md; cbc_en = cbc; key = k; iv = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input string nm, input logic [7:0] d,
                      input bit last, input logic [7:0] exp);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_accept"}, 32'(n < 20), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, "_data"}, out_data, exp);
    check({nm, "_last"}, out_last, last);
  endtask

  task automatic finish_chk(input string nm);
    @(negedge clk);
    check({nm, "_idle"}, busy, 0);
  endtask

  task automatic stream(input int n);
    int idx = 0;
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < n + 50) begin
      in_valid = (idx < n);
      in_data  = sbuf[(idx < n) ? idx : 0];
      in_last  = (idx == n - 1);
      #1;
      if (out_valid && out_ready) begin
        obuf[got] = out_data;
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    check("stream_count", got, n);
    check("stream_cycles", cyc, n + 1);
    check("stream_idle", busy, 0);
  endtask

  initial begin
    int errs;
    logic [7:0] k;
    vecs[0] = '{0, 0, 8'h0F, 8'h00, 8'hA5, 8'h55};
    vecs[1] = '{1, 0, 8'h0F, 8'h00, 8'h55, 8'hA5};
    vecs[2] = '{0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF};
    vecs[3] = '{0, 0, 8'h00, 8'h00, 8'h01, 8'h02};
    vecs[4] = '{1, 0, 8'h00, 8'h00, 8'h80, 8'h40};
    vecs[5] = '{0, 1, 8'h00, 8'h01, 8'h00, 8'h02};
    vecs[6] = '{0, 1, 8'h33, 8'hC0, 8'h00, 8'hF3};
    vecs[7] = '{1, 1, 8'h0F, 8'h10, 8'h55, 8'hB5};
    vecs[8] = '{0, 0, 8'h0F, 8'hFF, 8'hA5, 8'h55};

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_start(vecs[i].md, vecs[i].cbc, vecs[i].k, vecs[i].v);
      send($sformatf("vec%0d", i), vecs[i].din, 1'b1, vecs[i].dout);
      check($sformatf("vec%0d_cnt", i), blk_cnt, 1);
      finish_chk($sformatf("vec%0d", i));
    end

    do_start(0, 1, 8'h00, 8'h01);
    send("cbc_e0", 8'h00, 1'b0, 8'h02);
    send("cbc_e1", 8'h00, 1'b1, 8'h01);
    finish_chk("cbc_e");
    do_start(1, 1, 8'h00, 8'h01);
    send("cbc_d0", 8'h02, 1'b0, 8'h00);
    send("cbc_d1", 8'h01, 1'b1, 8'h00);
    finish_chk("cbc_d");

    k = 8'($urandom);
    for (int i = 0; i < 256; i++) pt[i] = 8'($urandom);
    do_start(0, 0, k, 8'h00);
    sbuf = pt;
    stream(256);
    ct = obuf;
    check("rt_cnt", blk_cnt, 256);
    do_start(1, 0, k, 8'h00);
    sbuf = ct;
    stream(256);
    errs = 0;
    for (int i = 0; i < 256; i++) if (obuf[i] !== pt[i]) errs++;
    check("roundtrip_errs", errs, 0);

    do_start(0, 0, 8'h0F, 8'h00);
    out_ready = 1'b0;
    send("stall_a", 8'hA5, 1'b0, 8'h55);
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 8'h55);
      check("stall_in_ready", in_ready, 0);
      check("stall_cnt", blk_cnt, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", in_ready, 1);
    @(negedge clk);
    check("pipe_b_data", out_data, 8'hAA);
    check("pipe_b_cnt", blk_cnt, 2);
    in_data = 8'h01; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("pipe_c_data", out_data, 8'h0D);
    check("pipe_c_last", out_last, 1);
    check("pipe_c_cnt", blk_cnt, 3);
    finish_chk("pipe");

    do_start(0, 0, 8'h0F, 8'h00);
    send("rs_a", 8'hA5, 1'b0, 8'h55);
    start = 1'b1; key = 8'hFF; mode_dec = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send("rs_b", 8'hA5, 1'b1, 8'h55);
    check("rs_cnt", blk_cnt, 2);
    finish_chk("rs");

    do_start(0, 0, 8'h0F, 8'h00);
    send("rst_b0", 8'h00, 1'b0, 8'h0F);
    send("rst_b1", 8'hA5, 1'b0, 8'h55);
    send("rst_b2", 8'h5A, 1'b0, 8'hAA);
    check("pre_rst_cnt", blk_cnt, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt", blk_cnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_in_ready", in_ready, 0);
      check("post_rst_valid", out_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    do_start(0, 0, 8'h0F, 8'h00);
    send("post_rst_blk", 8'hA5, 1'b1, 8'h55);
    finish_chk("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/block_cipher_stream.md
BLOCK_CIPHER_STREAM -- requirements
Module: block_cipher_stream

Interface
REQ-001 Parameter W, default 8, block width in bits; SHALL be even and >= 4.
REQ-002 Parameter CNT_W, default 16, width of the block counter.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to load configuration; honoured only in IDLE.
REQ-006 mode_dec  in  1  0 = encrypt, 1 = decrypt; sampled at accepted start.
REQ-007 cbc_en  in  1  0 = ECB, 1 = CBC chaining; sampled at accepted start.
REQ-008 key  in  W  key; sampled at accepted start.
REQ-009 iv  in  W  initial chain value; sampled at accepted start.
REQ-010 in_valid / in_ready / in_data[W] / in_last  in/out/in/in  input block stream with valid-ready handshake.
REQ-011 out_valid / out_ready / out_data[W] / out_last  out/in/out/out  output block stream with valid-ready handshake.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 blk_cnt  out  CNT_W  number of blocks accepted since the last accepted start.

Function
REQ-014 swap(x) SHALL exchange bits 2i and 2i+1 for every i in 0..W/2-1.
REQ-015 Encrypt: c = swap(p ^ key ^ chain); decrypt: p = swap(c) ^ key ^ chain; chain = 0 when cbc_en = 0.
REQ-016 The chain register SHALL load iv at accepted start; on each accepted input block in CBC mode it SHALL load the ciphertext (encrypt: produced output; decrypt: in_data).
REQ-017 FSM states: IDLE, RUN, DRAIN.
REQ-018 IDLE -> RUN on start = 1; key, iv, mode_dec, cbc_en are latched and blk_cnt cleared in the same edge.
REQ-019 RUN -> DRAIN on acceptance of a block with in_last = 1.
REQ-020 DRAIN -> IDLE when the output block carrying out_last = 1 is accepted.
REQ-021 start in RUN or DRAIN SHALL be ignored, with no effect on configuration or counters.
REQ-022 in_ready = (state == RUN) && (!out_valid || out_ready); combinational, no input-to-output pass-through of in_valid.
REQ-023 A block is accepted when in_valid && in_ready; out_data/out_last are registered, so latency is exactly one cycle.
REQ-024 out_valid, out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 Simultaneous output accept and input accept SHALL sustain one block per clock with no bubble.
REQ-026 out_valid SHALL clear on output accept when no new block is accepted in the same cycle.
REQ-027 blk_cnt SHALL increment by 1 per accepted block and wrap modulo 2^CNT_W.
REQ-028 in_data and in_last are ignored when in_ready = 0; in_valid in IDLE/DRAIN is not consumed.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, out_valid 0, out_data 0, out_last 0, busy 0, blk_cnt 0, chain 0, latched key 0, mode_dec 0, cbc_en 0.
REQ-030 Reset asserted mid-stream SHALL discard any pending output block; after release the block waits for a new start.

Verification
REQ-031 W=8, ECB encrypt, key=0x0F, one block 0xA5 with in_last -> out_data 0x55, out_last 1, one cycle after accept; then busy 0.
REQ-032 W=8, ECB decrypt, key=0x0F, block 0x55 -> out_data 0xA5; encrypt-then-decrypt round trip of 256 random blocks returns originals.
REQ-033 W=8, CBC encrypt, key=0x00, iv=0x01, blocks 0x00, 0x00 -> outputs 0x02, 0x01; CBC decrypt of 0x02, 0x01 with same iv -> 0x00, 0x00.
REQ-034 out_ready held low 5 cycles with one block pending -> out_data stable, in_ready 0, blk_cnt unchanged; out_ready high with in_valid high -> one block per cycle.
REQ-035 start pulsed during RUN with different key -> ignored; outputs still use original key; blk_cnt continues.
REQ-036 rst_n low for one cycle after 3 of 5 blocks accepted -> out_valid 0, blk_cnt 0, busy 0 immediately; in_ready stays 0 until next start.
